// File: rtl/lcd_bus_pkg.sv
// lcd_bus_pkg: shared state encoding, instruction opcodes and address-counter width
package lcd_bus_pkg;
  typedef enum logic [1:0] {IDLE, WR_LO, RD_HI, RD_LO} state_t;
  localparam logic [7:0] CLEAR = 8'h01;
  localparam logic [7:0] HOME = 8'h02;
  localparam logic [7:0] FUNC_SET = 8'h20;
  localparam logic [7:0] SET_DDRAM = 8'h80;
  localparam int AC_W = 7;
  function automatic logic is_long(input logic [7:0] b);
    return b == CLEAR || b[7:1] == HOME[7:1];
  endfunction
  function automatic logic is_func_set(input logic [7:0] b);
    return b[7:5] == FUNC_SET[7:5];
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous bus pins
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] m;
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      m <= '0;
      q <= '0;
    end else begin
      m <= d;
      q <= m;
    end
endmodule

// File: rtl/lcd_bus_responder.sv
// lcd_bus_responder: HD44780-style 4/8-bit bus target with busy timing and AC tracking
module lcd_bus_responder
  import lcd_bus_pkg::*;
#(
  parameter logic [15:0] SHORT_BUSY = 16'd1000,
  parameter logic [15:0] LONG_BUSY = 16'd41000
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  input  logic            lcd_en,
  input  logic            lcd_rs,
  input  logic            lcd_rw,
  input  logic [3:0]      lcd_d_in,
  output logic [3:0]      lcd_d_out,
  output logic            lcd_d_oe,
  output logic            cmd_valid,
  output logic [7:0]      cmd_data,
  output logic            wr_valid,
  output logic [7:0]      wr_data,
  output logic [AC_W-1:0] wr_addr,
  output logic            rd_strobe,
  output logic [AC_W-1:0] rd_addr,
  input  logic [7:0]      rd_data,
  output logic            busy,
  output logic            busy_violation
);
  logic en_s, rs_s, rw_s, en_d, mode8, hi_rs, rd_pend, done, b_rs, rise, fall;
  logic [3:0] d_s, hi_nib, stat_lo, rd_lo;
  logic [7:0] b_val;
  logic [15:0] busy_cnt;
  logic [AC_W-1:0] ac;
  state_t state;
  sync_2ff #(.W(7)) u_sync (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .d        ({lcd_en, lcd_rs, lcd_rw, lcd_d_in}),
    .q        ({en_s, rs_s, rw_s, d_s})
  );
  assign rise = en_s && !en_d;
  assign fall = !en_s && en_d;
  assign busy = busy_cnt != 16'd0;
  // a byte completes on a write fall in 8-bit idle, or on the low-nibble fall in 4-bit mode
  assign done = fall && ((state == IDLE && !rw_s && mode8) || state == WR_LO);
  assign b_val = state == WR_LO ? {hi_nib, d_s} : {d_s, 4'h0};
  assign b_rs = state == WR_LO ? hi_rs : rs_s;
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      en_d <= 1'b0;
      mode8 <= 1'b1;
      hi_rs <= 1'b0;
      hi_nib <= '0;
      stat_lo <= '0;
      rd_lo <= '0;
      rd_pend <= 1'b0;
      busy_cnt <= '0;
      ac <= '0;
      state <= IDLE;
      lcd_d_out <= '0;
      lcd_d_oe <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_data <= '0;
      wr_valid <= 1'b0;
      wr_data <= '0;
      wr_addr <= '0;
      rd_strobe <= 1'b0;
      rd_addr <= '0;
      busy_violation <= 1'b0;
    end else begin
      en_d <= en_s;
      cmd_valid <= 1'b0;
      wr_valid <= 1'b0;
      rd_strobe <= 1'b0;
      busy_violation <= 1'b0;
      rd_pend <= rd_strobe;
      if (rd_pend) begin
        rd_lo <= rd_data[3:0];
        lcd_d_out <= rd_data[7:4];
      end
      if (done) begin
        busy_cnt <= (!b_rs && is_long(b_val)) ? LONG_BUSY : SHORT_BUSY;
        busy_violation <= busy;
        if (b_rs) begin
          wr_valid <= 1'b1;
          wr_data <= b_val;
          wr_addr <= ac;
          ac <= ac + 7'd1;
        end else begin
          cmd_valid <= 1'b1;
          cmd_data <= b_val;
          if (|(b_val & SET_DDRAM)) ac <= b_val[6:0];
          else if (is_long(b_val)) ac <= '0;
          if (is_func_set(b_val)) mode8 <= b_val[4];
        end
      end else if (busy) busy_cnt <= busy_cnt - 16'd1;
      case (state)
        IDLE:
          if (fall && !rw_s && !mode8) begin
            hi_nib <= d_s;
            hi_rs <= rs_s;
            state <= WR_LO;
          end else if (rise && rw_s) begin
            hi_rs <= rs_s;
            stat_lo <= ac[3:0];
            lcd_d_oe <= 1'b1;
            if (rs_s) begin
              rd_strobe <= 1'b1;
              rd_addr <= ac;
            end else lcd_d_out <= {busy, ac[6:4]};
            state <= RD_HI;
          end
        RD_HI:
          if (fall) begin
            state <= mode8 ? IDLE : RD_LO;
            if (mode8 && hi_rs) ac <= ac + 7'd1;
          end
        WR_LO:
          if (fall) state <= IDLE;
        RD_LO:
          if (rise && rw_s) begin
            lcd_d_oe <= 1'b1;
            lcd_d_out <= hi_rs ? rd_lo : stat_lo;
          end else if (fall) begin
            state <= IDLE;
            if (hi_rs) ac <= ac + 7'd1;
          end
      endcase
      if (fall || !rw_s) lcd_d_oe <= 1'b0;
    end
endmodule

// File: tb/tb_lcd_bus_responder.sv
// tb_lcd_bus_responder: directed table plus hand sequences for the LCD bus target
module tb_lcd_bus_responder;
  logic sys_clk = 1'b0, sys_rst_n = 1'b0;
  logic lcd_en = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
  logic [3:0] lcd_d_in = 4'h0, lcd_d_out;
  logic lcd_d_oe, cmd_valid, wr_valid, rd_strobe, busy, busy_violation;
  logic [7:0] cmd_data, wr_data, rd_data;
  logic [6:0] wr_addr, rd_addr;
  int n_chk = 0, n_err = 0;
  int n_cmd = 0, n_wr = 0, n_viol = 0, n_stb = 0, n_busy = 0;
  logic [7:0] last_cmd = 8'h00, last_wd = 8'h00;
  logic [6:0] last_wa = 7'h00;

  always #5 sys_clk = ~sys_clk;
  assign rd_data = {1'b1, rd_addr};

  lcd_bus_responder dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .lcd_en(lcd_en), .lcd_rs(lcd_rs),
    .lcd_rw(lcd_rw), .lcd_d_in(lcd_d_in), .lcd_d_out(lcd_d_out), .lcd_d_oe(lcd_d_oe),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_addr(wr_addr), .rd_strobe(rd_strobe), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .busy_violation(busy_violation)
  );

  always @(negedge sys_clk) begin
    if (cmd_valid) begin
      n_cmd <= n_cmd + 1;
      last_cmd <= cmd_data;
    end
    if (wr_valid) begin
      n_wr <= n_wr + 1;
      last_wd <= wr_data;
      last_wa <= wr_addr;
    end
    if (busy_violation) n_viol <= n_viol + 1;
    if (rd_strobe) n_stb <= n_stb + 1;
    if (busy) n_busy <= n_busy + 1;
  end

  typedef struct {
    logic rw, rs;
    logic [3:0] d;
    logic wt;
    int n_cmd;
    logic [7:0] cmd;
    int n_wr;
    logic [7:0] wd;
    logic [6:0] wa;
    int n_viol;
    int n_stb;
    logic [3:0] q;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge sys_clk);
    #2;
  endtask

  task automatic pulse(input logic rw, input logic rs, input logic [3:0] d,
                       output logic [3:0] q, output logic oe);
    lcd_rw = rw;
    lcd_rs = rs;
    lcd_d_in = d;
    cyc(2);
    lcd_en = 1'b1;
    cyc(6);
    q = lcd_d_out;
    oe = lcd_d_oe;
    lcd_en = 1'b0;
    cyc(6);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 60000) begin
      cyc(1);
      k++;
    end
    chk("drain", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [3:0] q;
    logic oe;
    int c0, w0, v0, s0, b0;
    tbl.push_back('{1'b0, 1'b0, 4'h2, 1'b0, 1, 8'h20, 0, 8'h00, 7'h00, 0, 0, 4'h0});
    tbl.push_back('{1'b0, 1'b0, 4'h2, 1'b0, 0, 8'h00, 0, 8'h00, 7'h00, 0, 0, 4'h0});
    tbl.push_back('{1'b0, 1'b0, 4'h8, 1'b0, 1, 8'h28, 0, 8'h00, 7'h00, 1, 0, 4'h0});
    tbl.push_back('{1'b0, 1'b0, 4'hC, 1'b0, 0, 8'h00, 0, 8'h00, 7'h00, 0, 0, 4'h0});
    tbl.push_back('{1'b0, 1'b0, 4'h5, 1'b0, 1, 8'hC5, 0, 8'h00, 7'h00, 1, 0, 4'h0});
    tbl.push_back('{1'b0, 1'b1, 4'h4, 1'b0, 0, 8'h00, 0, 8'h00, 7'h00, 0, 0, 4'h0});
    tbl.push_back('{1'b0, 1'b1, 4'h2, 1'b0, 0, 8'h00, 1, 8'h42, 7'h45, 1, 0, 4'h0});
    tbl.push_back('{1'b1, 1'b0, 4'h0, 1'b1, 0, 8'h00, 0, 8'h00, 7'h00, 0, 0, 4'h4});
    tbl.push_back('{1'b1, 1'b0, 4'h0, 1'b0, 0, 8'h00, 0, 8'h00, 7'h00, 0, 0, 4'h6});
    tbl.push_back('{1'b0, 1'b0, 4'hF, 1'b0, 0, 8'h00, 0, 8'h00, 7'h00, 0, 0, 4'h0});
    tbl.push_back('{1'b0, 1'b0, 4'hF, 1'b0, 1, 8'hFF, 0, 8'h00, 7'h00, 0, 0, 4'h0});
    tbl.push_back('{1'b0, 1'b1, 4'h1, 1'b0, 0, 8'h00, 0, 8'h00, 7'h00, 0, 0, 4'h0});
    tbl.push_back('{1'b0, 1'b1, 4'h0, 1'b0, 0, 8'h00, 1, 8'h10, 7'h7F, 1, 0, 4'h0});
    tbl.push_back('{1'b1, 1'b0, 4'h0, 1'b1, 0, 8'h00, 0, 8'h00, 7'h00, 0, 0, 4'h0});
    tbl.push_back('{1'b1, 1'b0, 4'h0, 1'b0, 0, 8'h00, 0, 8'h00, 7'h00, 0, 0, 4'h0});
    tbl.push_back('{1'b0, 1'b0, 4'h9, 1'b0, 0, 8'h00, 0, 8'h00, 7'h00, 0, 0, 4'h0});
    tbl.push_back('{1'b0, 1'b0, 4'hA, 1'b0, 1, 8'h9A, 0, 8'h00, 7'h00, 0, 0, 4'h0});
    tbl.push_back('{1'b1, 1'b1, 4'h0, 1'b0, 0, 8'h00, 0, 8'h00, 7'h00, 0, 1, 4'h9});
    tbl.push_back('{1'b1, 1'b1, 4'h0, 1'b0, 0, 8'h00, 0, 8'h00, 7'h00, 0, 0, 4'hA});
    tbl.push_back('{1'b1, 1'b0, 4'h0, 1'b1, 0, 8'h00, 0, 8'h00, 7'h00, 0, 0, 4'h1});
    tbl.push_back('{1'b1, 1'b0, 4'h0, 1'b0, 0, 8'h00, 0, 8'h00, 7'h00, 0, 0, 4'hB});

    cyc(4);
    chk("rst_oe", {31'd0, lcd_d_oe}, 32'd0);
    chk("rst_outs", {lcd_d_out, cmd_valid, cmd_data, wr_valid, wr_data, rd_strobe, busy, busy_violation},
        32'd0);
    chk("rst_addr", {wr_addr, rd_addr}, 32'd0);
    sys_rst_n = 1'b1;
    cyc(3);
    chk("release_quiet", n_cmd + n_wr + n_viol + n_stb, 0);

    c0 = n_cmd;
    b0 = n_busy;
    pulse(1'b0, 1'b0, 4'h3, q, oe);
    chk("init_cmd_cnt", n_cmd - c0, 1);
    chk("init_cmd", {24'd0, last_cmd}, 32'h30);
    chk("init_busy", {31'd0, busy}, 32'd1);
    wait_idle();
    chk("short_busy_len", n_busy - b0, 1000);

    foreach (tbl[i]) begin
      if (tbl[i].wt) wait_idle();
      c0 = n_cmd;
      w0 = n_wr;
      v0 = n_viol;
      s0 = n_stb;
      pulse(tbl[i].rw, tbl[i].rs, tbl[i].d, q, oe);
      chk($sformatf("v%0d_ncmd", i), n_cmd - c0, tbl[i].n_cmd);
      if (tbl[i].n_cmd > 0) chk($sformatf("v%0d_cmd", i), {24'd0, last_cmd}, {24'd0, tbl[i].cmd});
      chk($sformatf("v%0d_nwr", i), n_wr - w0, tbl[i].n_wr);
      if (tbl[i].n_wr > 0) begin
        chk($sformatf("v%0d_wdata", i), {24'd0, last_wd}, {24'd0, tbl[i].wd});
        chk($sformatf("v%0d_waddr", i), {25'd0, last_wa}, {25'd0, tbl[i].wa});
      end
      chk($sformatf("v%0d_viol", i), n_viol - v0, tbl[i].n_viol);
      chk($sformatf("v%0d_stb", i), n_stb - s0, tbl[i].n_stb);
      chk($sformatf("v%0d_oe_hi", i), {31'd0, oe}, {31'd0, tbl[i].rw});
      if (tbl[i].rw) chk($sformatf("v%0d_nibble", i), {28'd0, q}, {28'd0, tbl[i].q});
      chk($sformatf("v%0d_oe_lo", i), {31'd0, lcd_d_oe}, 32'd0);
    end

    wait_idle();
    b0 = n_busy;
    c0 = n_cmd;
    pulse(1'b0, 1'b0, 4'h0, q, oe);
    pulse(1'b0, 1'b0, 4'h1, q, oe);
    chk("clear_cmd_cnt", n_cmd - c0, 1);
    chk("clear_cmd", {24'd0, last_cmd}, 32'h01);
    pulse(1'b1, 1'b0, 4'h0, q, oe);
    chk("clear_stat_hi", {28'd0, q}, 32'h8);
    pulse(1'b1, 1'b0, 4'h0, q, oe);
    chk("clear_stat_lo", {28'd0, q}, 32'h0);
    wait_idle();
    chk("long_busy_len", n_busy - b0, 41000);
    pulse(1'b1, 1'b0, 4'h0, q, oe);
    chk("idle_stat_hi", {28'd0, q}, 32'h0);
    pulse(1'b1, 1'b0, 4'h0, q, oe);
    chk("idle_stat_lo", {28'd0, q}, 32'h0);

    lcd_rw = 1'b1;
    lcd_rs = 1'b0;
    cyc(2);
    lcd_en = 1'b1;
    cyc(6);
    chk("rd_oe_before_rst", {31'd0, lcd_d_oe}, 32'd1);
    sys_rst_n = 1'b0;
    #1;
    chk("rd_oe_in_rst", {31'd0, lcd_d_oe}, 32'd0);
    lcd_en = 1'b0;
    lcd_rw = 1'b0;
    cyc(4);
    sys_rst_n = 1'b1;
    cyc(2);
    pulse(1'b0, 1'b0, 4'h2, q, oe);
    w0 = n_wr;
    pulse(1'b0, 1'b1, 4'h4, q, oe);
    sys_rst_n = 1'b0;
    #1;
    chk("wr_rst_oe", {31'd0, lcd_d_oe}, 32'd0);
    chk("wr_rst_busy", {31'd0, busy}, 32'd0);
    cyc(3);
    sys_rst_n = 1'b1;
    cyc(3);
    c0 = n_cmd;
    pulse(1'b0, 1'b0, 4'h3, q, oe);
    chk("rst_mode8_cnt", n_cmd - c0, 1);
    chk("rst_mode8_cmd", {24'd0, last_cmd}, 32'h30);
    chk("rst_no_wr", n_wr - w0, 0);
    chk("rst_end_oe", {31'd0, lcd_d_oe}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/lcd_bus_responder.md
LCD_BUS_RESPONDER -- requirements
Module: lcd_bus_responder
Synthesizable HD44780-compatible target for the SC1602 4-bit bus; loopback partner for the LCD driver.

Interface
REQ-001 SHALL have parameter SHORT_BUSY, default 16'd1000, meaning busy cycles after ordinary instruction or data write.
REQ-002 SHALL have parameter LONG_BUSY, default 16'd41000, meaning busy cycles after Clear Display (0x01) or Return Home (0x02/0x03).
REQ-003 sys_clk  in  1  sole clock; all logic on rising edge.
REQ-004 sys_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 lcd_en  in  1  bus strobe E, asynchronous to sys_clk.
REQ-006 lcd_rs  in  1  register select: 0 = instruction/status, 1 = data.
REQ-007 lcd_rw  in  1  1 = read, 0 = write.
REQ-008 lcd_d_in  in  4  bus nibble D7..D4 from initiator.
REQ-009 lcd_d_out  out  4  nibble driven on reads.
REQ-010 lcd_d_oe  out  1  output enable for lcd_d_out.
REQ-011 cmd_valid / cmd_data  out  1 / 8  one-cycle pulse plus completed instruction byte.
REQ-012 wr_valid / wr_data / wr_addr  out  1 / 8 / 7  one-cycle pulse, data byte, and address counter (AC) at write time.
REQ-013 rd_strobe / rd_addr  out  1 / 7  one-cycle request at start of a data read; rd_data  in  8  SHALL be valid on the cycle after rd_strobe.
REQ-014 busy  out  1  busy flag; busy_violation  out  1  one-cycle pulse when a write completes while busy.

Function
REQ-015 lcd_en, lcd_rs, lcd_rw, and lcd_d_in SHALL pass through 2-flop synchronizers; E edges SHALL be detected from the synchronized signal (latency 3 cycles from pin).
REQ-016 Bus mode after reset SHALL be 8-bit emulation: each E falling edge with rw=0 completes a byte {lcd_d_in, 4'h0}.
REQ-017 A completed instruction byte with upper nibble 4'h2 or 4'h3 SHALL set mode: DL bit (bit 4) = 0 selects 4-bit, 1 selects 8-bit; nibble phase SHALL reset to HIGH.
REQ-018 In 4-bit mode, the first E fall SHALL capture the high nibble and the second the low nibble; the byte completes on the second fall.
REQ-019 A byte completed with rs=0 SHALL pulse cmd_valid; with rs=1 it SHALL pulse wr_valid and then increment AC (7-bit wrap 0x7F->0x00).
REQ-020 Instruction with bit7=1 SHALL load AC <= cmd_data[6:0]; 0x01, 0x02, and 0x03 SHALL load AC <= 0.
REQ-021 Each completed write SHALL load the busy counter with LONG_BUSY for 0x01/0x02/0x03, else SHORT_BUSY; busy = (counter != 0); counter decrements by 1 per cycle.
REQ-022 A write completing while busy=1 SHALL still be accepted, SHALL pulse busy_violation, and SHALL reload the counter.
REQ-023 Read, rs=0: on E rise SHALL assert lcd_d_oe and drive the high or low nibble of {busy, AC} per phase, with BF sampled at the high-nibble E rise.
REQ-024 Read, rs=1: a high-phase E rise SHALL pulse rd_strobe with rd_addr=AC and drive rd_data[7:4] by the 2nd cycle; the low phase SHALL drive the held rd_data[3:0]; AC SHALL increment on low-phase E fall.
REQ-025 lcd_d_oe SHALL deassert on the E falling edge or when synchronized rw=0, whichever comes first.
REQ-026 Reads SHALL advance the nibble phase identically to writes; a byte mixing rs or rw between its two nibbles SHALL use the values captured at the high nibble.
REQ-027 States SHALL be IDLE, WR_LO, RD_HI, RD_LO; a mode-change instruction in WR_LO or RD_LO SHALL return the machine to IDLE.

Reset
REQ-028 While sys_rst_n=0: mode 8-bit, phase HIGH, state IDLE, AC=0, busy counter=0, and all outputs 0, including lcd_d_oe=0.
REQ-029 Reset mid-byte SHALL discard the partial nibble; no pulse output SHALL fire on the release cycle.

Structure
REQ-030 A shared package lcd_bus_pkg SHALL hold the state enum, instruction opcodes (CLEAR, HOME, FUNC_SET, SET_DDRAM), and the AC width constant.
REQ-031 A single sub-module sync_2ff (parameterized width) SHALL implement the input synchronizers.

Verification
REQ-032 8-bit-mode write 0x3 via one E pulse -> cmd_valid with cmd_data=0x30; busy high for 1000 cycles.
REQ-033 Write 0x2 nibble, then in 4-bit mode send 0x28 as two nibbles -> mode 4-bit; cmd_data=0x28 pulses once on the second fall.
REQ-034 4-bit: instruction 0xC5, then data 0x42 -> wr_data=0x42 with wr_addr=0x45; AC becomes 0x46.
REQ-035 Status read immediately after 0x01 -> nibbles 0x8/0x0 (BF=1, AC=0); after 41000 cycles -> 0x0/0x0.
REQ-036 Data write during busy -> busy_violation pulse; AC at 0x7F wraps to 0x00.
REQ-037 sys_rst_n low between the two nibbles of a write -> no wr_valid; mode returns to 8-bit; lcd_d_oe=0.
